responder_arbiter: RTL
======================

// Module: responder_arbiter
// PURPOSE
//  Quiz-responder control core. Takes the four debounced contestant buttons (key_deb, high = pressed)
//  and the host controls, then decides who rang in first or who rang in early. It runs the answer
//  countdown and drives the winner, foul and timeout indications for the display and buzzer logic.
// PARAMETERS
//  TICK_MAX     49_999_999  prescaler terminal count; one countdown tick every TICK_MAX+1 clk (1 s @ 50 MHz)
//  DEF_TIME     30          countdown start value (seconds), used when cfg_time == 0
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  key_deb      in   4  debounced contestant keys, 1 = pressed; bit i = player i
//  start        in   1  host start level; rising edge arms the round
//  clear        in   1  host clear level; while high, forces IDLE
//  cfg_time     in   6  countdown preset, sampled on start edge; 0 selects DEF_TIME
//  state        out  3  one-hot {TIMEOUT,LOCKED|FOUL,ARMED}; 3'b000 = IDLE
//  winner_valid out  1  high in LOCKED
//  foul         out  1  high in FOUL
//  player_id    out  2  winner (LOCKED) or offender (FOUL); otherwise 0
//  timeout      out  1  high in TIMEOUT
//  time_left    out  6  remaining seconds
//  buzz         out  1  one-clk pulse on entry to LOCKED, FOUL or TIMEOUT
// BEHAVIOUR
//  - Reset values: IDLE, all outputs 0, time_left=0, prescaler=0, key_prev=4'b1111 and start_prev=1.
//    Keys or start already held at reset therefore produce no edge.
//  - Edge detect: kedge = key_deb & ~key_prev and sedge = start & ~start_prev, both combinational.
//    key_prev and start_prev update every clk. Only edges count; a held key never re-triggers.
//  - Priority, highest first: rst, then clear, then key edge, then start edge, then tick.
//  - IDLE:
//    - Any kedge goes to FOUL, with player_id = lowest set bit of kedge.
//    - Otherwise sedge goes to ARMED, loads time_left = (cfg_time ? cfg_time : DEF_TIME), prescaler = 0.
//  - ARMED:
//    - Prescaler counts 0..TICK_MAX and wraps.
//    - Any kedge goes to LOCKED, with player_id = lowest set bit (fixed priority 0>1>2>3), and time_left freezes.
//    - Otherwise, at prescaler == TICK_MAX: time_left -= 1. If time_left was 1, it becomes 0 and the block goes to TIMEOUT.
//    - A kedge in the same clk as the final tick gives LOCKED; time_left is not decremented.
//    - sedge in ARMED is ignored.
//  - LOCKED, FOUL and TIMEOUT are terminal.
//    - Outputs, player_id and time_left hold; further key and start edges are ignored.
//    - Exit is only via clear (or rst).
//  - clear high: next state IDLE, player_id = 0, time_left = 0, prescaler = 0. This applies mid-count too.
//    key_prev and start_prev keep tracking, so a key held through clear does not foul afterwards.
//  - Latency: all outputs are registered. The state change is visible 1 clk after the edge where kedge or sedge is sampled high.
//  - buzz is high exactly the first clk of LOCKED, FOUL or TIMEOUT.
//  - Prescaler runs only in ARMED; it holds 0 elsewhere.
//  - time_left never underflows or wraps.
// TESTING  (TICK_MAX=9, DEF_TIME=3 for sim)
//  1. rst, start edge with cfg_time=0, key_deb=4'b0100 after 15 clk
//     -> ARMED, time_left 3 then 2; LOCKED with player_id=2; buzz for 1 clk; time_left holds 2.
//  2. Start edge, then key_deb 4'b1010 rising in the same clk
//     -> LOCKED with player_id=1.
//  3. key_deb[3] rises in IDLE
//     -> FOUL with player_id=3 and buzz. A later start edge is ignored until clear.
//  4. Start edge with cfg_time=2, no keys
//     -> time_left 2, 1, 0 at 10-clk spacing; TIMEOUT and buzz together with time_left=0.
//  5. Key edge on the exact final-tick clk
//     -> LOCKED, time_left=1, no TIMEOUT.
//  6. Clear mid-count while key 0 is held throughout
//     -> IDLE with time_left=0. After clear drops: no FOUL; a new start edge arms normally.

Source files
------------

// File: rtl/responder_arbiter_if.sv
// Host and display signals of the quiz-responder core, grouped so that one
// port connects the core to whatever drives it and shows its results.
interface responder_arbiter_if;
  logic [3:0] key_deb;
  logic       start;
  logic       clear;
  logic [5:0] cfg_time;
  logic [2:0] state;
  logic       winner_valid;
  logic       foul;
  logic [1:0] player_id;
  logic       timeout;
  logic [5:0] time_left;
  logic       buzz;

  modport master (
    output key_deb, start, clear, cfg_time,
    input  state, winner_valid, foul, player_id, timeout, time_left, buzz
  );

  modport slave (
    input  key_deb, start, clear, cfg_time,
    output state, winner_valid, foul, player_id, timeout, time_left, buzz
  );
endinterface

// File: rtl/responder_arbiter.sv
// Quiz-responder control core: picks the first or early ring-in from four
// contestant keys and runs the answer countdown. All outputs are registered.
module responder_arbiter #(
  parameter int unsigned TICK_MAX = 49_999_999,
  parameter int unsigned DEF_TIME = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  responder_arbiter_if.slave   bus
);

  localparam int PW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_MAX);
  localparam logic [5:0]    DEF_LOAD = 6'(DEF_TIME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKED,
    S_FOUL,
    S_TIMEOUT
  } fsm_t;

  fsm_t          fsm;
  logic [3:0]    key_prev;
  logic          start_prev;
  logic [PW-1:0] prescaler;
  logic [3:0]    kedge;
  logic          sedge;

  assign kedge = bus.key_deb & ~key_prev;
  assign sedge = bus.start & ~start_prev;

  // Fixed priority: player 0 wins ties within the same clock.
  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm              <= S_IDLE;
      key_prev         <= 4'b1111;
      start_prev       <= 1'b1;
      prescaler        <= '0;
      bus.state        <= 3'b000;
      bus.winner_valid <= 1'b0;
      bus.foul         <= 1'b0;
      bus.player_id    <= 2'd0;
      bus.timeout      <= 1'b0;
      bus.time_left    <= 6'd0;
      bus.buzz         <= 1'b0;
    end else begin
      // Edge history tracks through every state, clear included.
      key_prev   <= bus.key_deb;
      start_prev <= bus.start;
      bus.buzz   <= 1'b0;

      if (bus.clear) begin
        fsm              <= S_IDLE;
        prescaler        <= '0;
        bus.state        <= 3'b000;
        bus.winner_valid <= 1'b0;
        bus.foul         <= 1'b0;
        bus.player_id    <= 2'd0;
        bus.timeout      <= 1'b0;
        bus.time_left    <= 6'd0;
      end else begin
        case (fsm)
          S_IDLE: begin
            if (|kedge) begin
              fsm           <= S_FOUL;
              bus.state     <= 3'b010;
              bus.foul      <= 1'b1;
              bus.player_id <= lowest(kedge);
              bus.buzz      <= 1'b1;
            end else if (sedge) begin
              fsm           <= S_ARMED;
              bus.state     <= 3'b001;
              prescaler     <= '0;
              bus.time_left <= (bus.cfg_time != 6'd0) ? bus.cfg_time : DEF_LOAD;
            end
          end

          S_ARMED: begin
            if (|kedge) begin
              // A ring-in beats a coincident final tick; time_left freezes.
              fsm              <= S_LOCKED;
              bus.state        <= 3'b010;
              bus.winner_valid <= 1'b1;
              bus.player_id    <= lowest(kedge);
              bus.buzz         <= 1'b1;
              prescaler        <= '0;
            end else if (prescaler == PRE_MAX) begin
              prescaler <= '0;
              if (bus.time_left <= 6'd1) begin
                fsm           <= S_TIMEOUT;
                bus.state     <= 3'b100;
                bus.timeout   <= 1'b1;
                bus.buzz      <= 1'b1;
                bus.time_left <= 6'd0;
              end else begin
                bus.time_left <= bus.time_left - 6'd1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end

          default: begin
            // LOCKED, FOUL and TIMEOUT hold until clear.
          end
        endcase
      end
    end
  end

endmodule
